// File: rtl/round_down_counter.sv
// round_down_counter: 6-bit SHA-256 round down-counter with Start/Empty/Done handshake.
// Define ROUND_DOWN_HOLD_EN to add the hold port that stalls counting in RUN.
module round_down_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] load,
`ifdef ROUND_DOWN_HOLD_EN
  input  logic       hold,
`endif
  output logic [5:0] count,
  output logic       busy,
  output logic       empty,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [5:0] dec;
  logic stall;
`ifdef ROUND_DOWN_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif
  // ripple-borrow subtract-one: a bit flips when every lower bit is zero
  genvar g;
  generate
    for (g = 0; g < 6; g++) begin : g_dec
      if (g == 0) begin : g_lsb
        assign dec[0] = ~count[0];
      end else begin : g_up
        assign dec[g] = count[g] ^ ~|count[g-1:0];
      end
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          count <= load;
          state <= RUN;
        end
        RUN: if (!stall) begin
          if (count != 6'd0) count <= dec;
          else state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign busy  = state == RUN;
  assign done  = state == DONE;
  assign empty = busy && count == 6'd0;
endmodule

// File: tb/tb_round_down_counter.sv
// tb_round_down_counter: directed checks of load, count-down, empty/done timing, ignored start and reset.
module tb_round_down_counter;
  logic clk = 1'b0;
  logic rst_n, start, hold;
  logic [5:0] load, count;
  logic busy, empty, done;
  int nvec = 0;
  int nmis = 0;

  round_down_counter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load(load),
`ifdef ROUND_DOWN_HOLD_EN
    .hold(hold),
`endif
    .count(count), .busy(busy), .empty(empty), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input logic [5:0] c, input logic b, input logic e, input logic d);
    chk("count", count, c);
    chk("busy", {5'd0, busy}, {5'd0, b});
    chk("empty", {5'd0, empty}, {5'd0, e});
    chk("done", {5'd0, done}, {5'd0, d});
  endtask

  // call just after the accepting edge: expects from..0 in RUN, one DONE, then IDLE
  task automatic run_down(input int from);
    for (int i = from; i >= 0; i--) begin
      chk_all(6'(i), 1'b1, i == 0, 1'b0);
      step();
    end
    chk_all(6'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_all(6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; load = 6'h2A; hold = 1'b0;
    step();
    chk_all(6'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all(6'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; start = 1'b0;
    step();
    chk_all(6'd0, 1'b0, 1'b0, 1'b0);
    // full 64-round block
    start = 1'b1; load = 6'h3F;
    step();
    start = 1'b0;
    run_down(63);
    // zero and one loads
    start = 1'b1; load = 6'h00;
    step();
    start = 1'b0;
    run_down(0);
    start = 1'b1; load = 6'h01;
    step();
    start = 1'b0;
    run_down(1);
    // start ignored in RUN and DONE
    start = 1'b1; load = 6'h12;
    step();
    start = 1'b0;
    chk_all(6'h12, 1'b1, 1'b0, 1'b0);
    step();
    step();
    chk_all(6'h10, 1'b1, 1'b0, 1'b0);
    start = 1'b1; load = 6'h05;
    step();
    start = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      chk_all(6'(i), 1'b1, i == 0, 1'b0);
      step();
    end
    chk_all(6'd0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    step();
    chk_all(6'd0, 1'b0, 1'b0, 1'b0);
    step();
    start = 1'b0;
    run_down(5);
    // reset in the middle of a run
    start = 1'b1; load = 6'h28;
    step();
    start = 1'b0;
    repeat (8) step();
    chk_all(6'h20, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    chk_all(6'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_all(6'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; load = 6'h03;
    step();
    start = 1'b0;
    run_down(3);
`ifdef ROUND_DOWN_HOLD_EN
    start = 1'b1; load = 6'h03;
    step();
    start = 1'b0;
    chk_all(6'd3, 1'b1, 1'b0, 1'b0);
    step();
    chk_all(6'd2, 1'b1, 1'b0, 1'b0);
    hold = 1'b1;
    repeat (3) begin
      step();
      chk_all(6'd2, 1'b1, 1'b0, 1'b0);
    end
    hold = 1'b0;
    step();
    chk_all(6'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all(6'd0, 1'b1, 1'b1, 1'b0);
    hold = 1'b1;
    step();
    chk_all(6'd0, 1'b1, 1'b1, 1'b0);
    hold = 1'b0;
    step();
    chk_all(6'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_all(6'd0, 1'b0, 1'b0, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
